key_conditioner: RTL

//  Conditions raw DE2-115 push-buttons (KEY[3:0], active-low, bouncy, asynchronous) into clean

---
 rtl/key_cond_pkg.sv | 24 ++
 rtl/key_debounce_ch.sv | 131 +++++++++++++
 rtl/key_conditioner.sv | 44 ++++
 3 files changed

// File: rtl/key_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_cond_pkg
//  Description : Shared types and default timing constants for the key
//                conditioner (per-channel state encoding, 50 MHz defaults).
//  Revision    : 1.0  initial release
// ============================================================================
package key_cond_pkg;

    // Per-channel debounce state; two bits cover all four states.
    typedef enum logic [1:0] {
        S_UP    = 2'd0,
        S_DB_DN = 2'd1,
        S_DOWN  = 2'd2,
        S_DB_UP = 2'd3
    } key_state_e;

    // 10 ms debounce window at 50 MHz.
    localparam int KC_DEBOUNCE_50M = 500_000;
    // 1 s long-press threshold at 50 MHz.
    localparam int KC_LONG_50M     = 50_000_000;

endpackage
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_ch
//  Description : One push-button channel: 2-FF synchronizer, debounce FSM,
//                debounce and hold counters, registered press / release /
//                long-press strobes and debounced level.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce_ch
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYC = KC_DEBOUNCE_50M,
    parameter int LONG_CYC     = KC_LONG_50M
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_level
);

    // db_cnt only ever needs to reach DEBOUNCE_CYC-1; hold_cnt saturates at LONG_CYC.
    localparam int DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int HOLD_W = $clog2(LONG_CYC + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);

    logic              sync1;
    logic              sync2;
    logic              pressed;
    key_state_e        state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_done;
    logic              release_now;
    logic              hold_active;
    logic              long_now;

    // Two-flop synchronizer for the asynchronous pin; presets to "released".
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= i_key_n;
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;

    // A release being accepted this cycle takes precedence over the long strobe,
    // which keeps the three strobes mutually exclusive.
    assign release_now = (state == S_DB_UP) && !pressed && (db_cnt == DB_LAST);
    assign hold_active = ((state == S_DOWN) || (state == S_DB_UP)) && !release_now;
    assign long_now    = hold_active && (hold_cnt == HOLD_LAST) && !long_done;

    // Debounce FSM with counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_UP;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            long_done <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            o_level   <= 1'b0;
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= long_now;

            // Hold time base runs through release glitches and saturates.
            if (hold_active && (hold_cnt != HOLD_MAX)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (long_now) begin
                long_done <= 1'b1;
            end

            case (state)
                S_UP: begin
                    if (pressed) begin
                        state  <= S_DB_DN;
                        db_cnt <= '0;
                    end
                end
                S_DB_DN: begin
                    if (!pressed) begin
                        state <= S_UP;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= S_DOWN;
                        o_press   <= 1'b1;
                        o_level   <= 1'b1;
                        hold_cnt  <= '0;
                        long_done <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                S_DOWN: begin
                    if (!pressed) begin
                        state  <= S_DB_UP;
                        db_cnt <= '0;
                    end
                end
                S_DB_UP: begin
                    if (pressed) begin
                        state <= S_DOWN;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= S_UP;
                        o_release <= 1'b1;
                        o_level   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_UP;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : key_conditioner
//  Description : Conditions N_KEYS raw active-low push-buttons into clean
//                one-cycle press / release / long-press strobes plus a
//                debounced level. Channels are identical and independent.
//  Revision    : 1.0  initial release
// ============================================================================
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_KEYS       = 4,
    parameter int DEBOUNCE_CYC = KC_DEBOUNCE_50M,
    parameter int LONG_CYC     = KC_LONG_50M
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_KEYS-1:0] i_key_n,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_KEYS-1:0] o_long,
    output logic [N_KEYS-1:0] o_level
);

    // One debounce channel per key; no cross-channel priority or masking.
    generate
        for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
            key_debounce_ch #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC),
                .LONG_CYC     (LONG_CYC)
            ) u_ch (
                .i_clk     (i_clk),
                .i_rst_n   (i_rst_n),
                .i_key_n   (i_key_n[k]),
                .o_press   (o_press[k]),
                .o_release (o_release[k]),
                .o_long    (o_long[k]),
                .o_level   (o_level[k])
            );
        end
    endgenerate

endmodule
`default_nettype wire
